// File: rtl/multicycle_seq_ctrl.sv
// multicycle_seq_ctrl
//   Multi-cycle sequencer for the 16-bit RISC core. It owns the PC and the
//   instruction register. Each instruction steps through
//   FETCH/DECODE/EXEC/MEM/WB, using req/ack handshakes to the instruction
//   memory, the data memory and the multi-cycle MUL/DIV unit.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-low reset
//   run             execute when 1; park in IDLE at the next instruction boundary when 0
//   imem_*          instruction fetch handshake (addr = pc_out)
//   ir, opcode      latched instruction and its op field
//   pc_out          current PC
//   alu_start/done  MUL/DIV start pulse and completion
//   dmem_*          data memory handshake (we = store)
//   reg_wr_en       one-cycle register-file write strobe
//   link_wr         one-cycle strobe for the R15 <- pc_out+1 write (JAL)
//   fault           sticky timeout flag; cleared only by reset
//   state_dbg       current state encoding
module multicycle_seq_ctrl #(
    parameter int              PC_W     = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ir,
    output logic [3:0]      opcode,
    output logic [PC_W-1:0] pc_out,
    output logic            alu_start,
    input  logic            alu_done,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            reg_wr_en,
    output logic            link_wr,
    output logic            fault,
    output logic [2:0]      state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h6;
    localparam logic [3:0] OP_JAL  = 4'h7;
    localparam logic [3:0] OP_JUMP = 4'hA;
    localparam logic [3:0] OP_LW   = 4'hC;
    localparam logic [3:0] OP_SW   = 4'hD;

    // A wait that has already seen TIMEOUT-1 idle cycles faults if this
    // cycle is idle as well; an ack in that same cycle still wins.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     ir_nxt;
    logic [7:0]      wait_cnt, wait_nxt;
    state_t          boundary;

    assign opcode    = ir[15:12];
    assign imem_addr = pc_out;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc_out   <= RESET_PC;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pc_out   <= pc_nxt;
            ir       <= ir_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_out;
        ir_nxt    = ir;
        wait_nxt  = wait_cnt;
        imem_req  = 1'b0;
        alu_start = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_wr_en = 1'b0;
        link_wr   = 1'b0;
        fault     = 1'b0;
        // run is consulted only where an instruction retires.
        boundary  = run ? S_FETCH : S_IDLE;

        unique case (state)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = S_DECODE;
                end else if (wait_cnt == TO_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end

            S_DECODE: state_nxt = S_EXEC;

            S_EXEC: begin
                case (opcode)
                    OP_MUL, OP_DIV: begin
                        // wait_cnt is still zero only on the first EXEC
                        // cycle, so this yields a single start pulse.
                        alu_start = (wait_cnt == 8'd0);
                        if (alu_done) begin
                            state_nxt = S_WB;
                        end else if (wait_cnt == TO_LAST) begin
                            state_nxt = S_FAULT;
                        end else begin
                            wait_nxt = wait_cnt + 8'd1;
                        end
                    end
                    OP_JUMP: begin
                        pc_nxt    = ir[PC_W-1:0];
                        state_nxt = boundary;
                    end
                    OP_JAL: begin
                        // The link value uses the current pc_out, before the jump lands.
                        link_wr   = 1'b1;
                        pc_nxt    = ir[PC_W-1:0];
                        state_nxt = boundary;
                    end
                    OP_LW, OP_SW: state_nxt = S_MEM;
                    OP_NOP: begin
                        pc_nxt    = pc_out + 1'b1;
                        state_nxt = boundary;
                    end
                    default: state_nxt = S_WB;
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_SW);
                if (dmem_ack) begin
                    if (opcode == OP_SW) begin
                        pc_nxt    = pc_out + 1'b1;
                        state_nxt = boundary;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (wait_cnt == TO_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end

            S_WB: begin
                reg_wr_en = 1'b1;
                pc_nxt    = pc_out + 1'b1;
                state_nxt = boundary;
            end

            S_FAULT: fault = 1'b1;

            default: state_nxt = S_IDLE;
        endcase

        // Every wait starts with a fresh count. Clearing the count on any
        // state change covers entry to FETCH, MEM and the EXEC wait.
        if (state_nxt != state) wait_nxt = '0;
    end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
module tb_multicycle_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [5:0]  pc_out;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        reg_wr_en;
    logic        link_wr;
    logic        fault;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int starts;

    multicycle_seq_ctrl #(.PC_W(6), .RESET_PC(6'd0), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .opcode(opcode), .pc_out(pc_out),
        .alu_start(alu_start), .alu_done(alu_done),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_wr_en(reg_wr_en), .link_wr(link_wr), .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called in FETCH: return instr on the first fetch cycle; ends in DECODE.
    task automatic fetch_issue(input logic [15:0] instr);
        imem_rdata = instr;
        imem_ack   = 1'b1;
        cyc();
        imem_ack   = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_state", state_dbg, 3'd0);
        chk("rst_pc", pc_out, 6'd0);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_fault", fault, 1'b0);
        rst = 1'b1;
        cyc();
        chk("idle_hold", state_dbg, 3'd0);

        // 1: ADD at pc=0, fetched on the first FETCH cycle
        run = 1'b1;
        cyc();
        chk("add_fetch_state", state_dbg, 3'd1);
        chk("add_imem_req", imem_req, 1'b1);
        chk("add_imem_addr", imem_addr, 6'd0);
        fetch_issue(16'h1123);
        chk("add_decode_state", state_dbg, 3'd2);
        chk("add_ir", ir, 16'h1123);
        chk("add_opcode", opcode, 4'h1);
        chk("add_c2_wr", reg_wr_en, 1'b0);
        cyc();
        chk("add_c3_wr", reg_wr_en, 1'b0);
        cyc();
        chk("add_c4_wr", reg_wr_en, 1'b1);
        chk("add_c4_state", state_dbg, 3'd5);
        cyc();
        chk("add_c5_wr", reg_wr_en, 1'b0);
        chk("add_pc", pc_out, 6'd1);
        chk("add_refetch", state_dbg, 3'd1);

        // 2: LW at pc=1, dmem_ack delayed 3 cycles
        fetch_issue(16'hC210);
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("lw_dmem_req", dmem_req, 1'b1);
            chk("lw_dmem_we", dmem_we, 1'b0);
            chk("lw_wr_early", reg_wr_en, 1'b0);
            if (i == 3) dmem_ack = 1'b1;
            cyc();
        end
        dmem_ack = 1'b0;
        chk("lw_wb_wr", reg_wr_en, 1'b1);
        chk("lw_wb_req", dmem_req, 1'b0);
        cyc();
        chk("lw_pc", pc_out, 6'd2);
        chk("lw_wr_off", reg_wr_en, 1'b0);

        // SW at pc=2: store, no register write
        fetch_issue(16'hD345);
        cyc();
        chk("sw_exec_wr", reg_wr_en, 1'b0);
        cyc();
        chk("sw_dmem_req", dmem_req, 1'b1);
        chk("sw_dmem_we", dmem_we, 1'b1);
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        chk("sw_no_wr", reg_wr_en, 1'b0);
        chk("sw_state", state_dbg, 3'd1);
        chk("sw_pc", pc_out, 6'd3);

        // Two NOPs walk pc to 5
        fetch_issue(16'h0000);
        cyc();
        chk("nop_no_wr", reg_wr_en, 1'b0);
        cyc();
        chk("nop_pc4", pc_out, 6'd4);
        fetch_issue(16'h0000);
        cyc(); cyc();
        chk("nop_pc5", pc_out, 6'd5);

        // 3: JAL at pc=5 to 0x3A
        fetch_issue(16'h723A);
        cyc();
        chk("jal_link", link_wr, 1'b1);
        chk("jal_pc_during", pc_out, 6'd5);
        chk("jal_no_start", alu_start, 1'b0);
        cyc();
        chk("jal_link_off", link_wr, 1'b0);
        chk("jal_pc", pc_out, 6'h3A);

        // JUMP 0x3A -> 63, NOP at 63 wraps to 0
        fetch_issue(16'hA03F);
        cyc(); cyc();
        chk("jump_pc63", pc_out, 6'd63);
        fetch_issue(16'h0000);
        cyc(); cyc();
        chk("nop_wrap", pc_out, 6'd0);

        // JUMP 0 -> 63, then JUMP at 63 to 0
        fetch_issue(16'hA03F);
        cyc(); cyc();
        chk("jump_pc63b", pc_out, 6'd63);
        fetch_issue(16'hA000);
        cyc(); cyc();
        chk("jump_to0", pc_out, 6'd0);

        // 4: DIV with alu_done in the 7th EXEC cycle
        fetch_issue(16'h6123);
        cyc();
        starts = 0;
        for (int i = 0; i < 7; i++) begin
            if (alu_start) starts++;
            chk("div_exec_state", state_dbg, 3'd3);
            chk("div_no_wr", reg_wr_en, 1'b0);
            if (i == 6) alu_done = 1'b1;
            cyc();
        end
        alu_done = 1'b0;
        chk("div_one_start", starts, 1);
        chk("div_wb_wr", reg_wr_en, 1'b1);
        chk("div_wb_nostart", alu_start, 1'b0);
        cyc();
        chk("div_pc", pc_out, 6'd1);

        // Timeout: imem_ack withheld for 15 cycles
        for (int i = 0; i < 15; i++) begin
            chk("to_imem_req", imem_req, 1'b1);
            cyc();
        end
        chk("to_fault", fault, 1'b1);
        chk("to_state", state_dbg, 3'd7);
        chk("to_req_off", imem_req, 1'b0);
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        chk("to_sticky", state_dbg, 3'd7);
        chk("to_fault_sticky", fault, 1'b1);

        // 5: recover with reset, drop run during LW MEM wait
        rst = 1'b0;
        #1;
        chk("rec_state", state_dbg, 3'd0);
        chk("rec_fault", fault, 1'b0);
        rst = 1'b1;
        cyc();
        chk("rec_fetch", state_dbg, 3'd1);
        fetch_issue(16'hC111);
        cyc(); cyc();
        chk("run_mem_state", state_dbg, 3'd4);
        run = 1'b0;
        cyc(); cyc();
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        chk("run_lw_wr", reg_wr_en, 1'b1);
        cyc();
        chk("run_idle", state_dbg, 3'd0);
        chk("run_pc", pc_out, 6'd1);
        cyc();
        chk("run_idle_req", imem_req, 1'b0);

        // Async reset mid-FETCH
        run = 1'b1;
        cyc();
        chk("arst_pre_req", imem_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", imem_req, 1'b0);
        chk("arst_pc", pc_out, 6'd0);
        chk("arst_state", state_dbg, 3'd0);
        rst = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
